combo_lock_param: RTL and testbench
===================================

# combo_lock_param

Parametrised successor to the 3-bit serial combination lock. It accepts a bit-serial code of CODE_LEN bits on a strobed input and compares it against a stored code register. It counts failed attempts and enters a timed lockout after MAX_TRIES consecutive failures. It sits between the keypad/switch debounce logic and the LED/actuator drivers.

## Interface
- CODE_LEN, 3: code length in bits (≥2)
- CODE_DEFAULT, 3'b101: code register value after reset (CODE_LEN bits)
- MAX_TRIES, 3: consecutive failed attempts before lockout (≥1)
- LOCKOUT_CYCLES, 16: lockout duration in clk cycles (≥1)

- clk  in  1  system clock, rising edge
- clr_n  in  1  asynchronous, active-low reset
- data_in  in  1  serial code bit, sampled when data_valid=1
- data_valid  in  1  bit strobe; one bit per cycle where high
- relock  in  1  return from UNLOCKED to LOCKED
- prog  in  1  load new code (only with COMBO_LOCK_PROG_EN)
- q  out  CODE_LEN  shift-register contents, newest bit in q[0]
- fail_cnt  out  $clog2(MAX_TRIES+1)  consecutive failed attempts
- lock_led  out  1  high in LOCKED and LOCKOUT
- unlock_led  out  1  high in UNLOCKED
- alarm_led  out  1  high in LOCKOUT

## Operation
- States: LOCKED, UNLOCKED, LOCKOUT. All outputs are registered or decoded from state registers only.
- Reset (clr_n=0, asynchronous): state=LOCKED, q=0, bit_cnt=0, fail_cnt=0, lockout timer=0, code=CODE_DEFAULT, lock_led=1, unlock_led=0, alarm_led=0.
- LOCKED, data_valid=1: q <= {q[CODE_LEN-2:0], data_in}; bit_cnt++.
- On the edge that accepts bit CODE_LEN, compare {q[CODE_LEN-2:0], data_in} with code:
  - Match: go to UNLOCKED; fail_cnt <= 0; q holds the entered code; bit_cnt <= 0.
  - Mismatch: q <= 0; bit_cnt <= 0; fail_cnt++. If the new fail_cnt equals MAX_TRIES, go to LOCKOUT and load the timer with LOCKOUT_CYCLES.
- Gaps in data_valid do not abort entry. A partial code persists until completion or reset.
- LOCKOUT: data_valid, relock and prog are ignored; the timer decrements each cycle. When the timer reaches 0: go to LOCKED, fail_cnt <= 0, q <= 0.
- UNLOCKED: relock=1 → LOCKED, q <= 0, bit_cnt <= 0. fail_cnt is unaffected (already 0).
- UNLOCKED, data_valid=1, relock=0: shift into q and count up to CODE_LEN (used for programming). Further bits beyond CODE_LEN keep shifting; bit_cnt saturates at CODE_LEN.
- Simultaneous relock and data_valid in UNLOCKED: relock wins and the bit is discarded.
- No combinational path from any input to any output.

## Timing
- Final bit sampled on edge k → unlock_led/lock_led/fail_cnt updated after edge k (visible in cycle k+1). Latency is 1 clock from the final strobe.
- q reflects each accepted bit one edge after its strobe.
- alarm_led is high for exactly LOCKOUT_CYCLES cycles. A data_valid in the first cycle after lockout ends is accepted.
- Reset is asynchronous on assertion and takes effect mid-entry or mid-lockout. Deassertion is assumed synchronised upstream.
- relock takes effect on the next edge.

## Configuration
- COMBO_LOCK_PROG_EN defined: in UNLOCKED, prog=1 with bit_cnt==CODE_LEN sets code <= q and goes to LOCKED with q <= 0. prog with bit_cnt<CODE_LEN is ignored. prog has priority over relock on the same edge.
- Not defined: prog is ignored and code is constant CODE_DEFAULT. The port remains for pin compatibility.

## Test plan
Defaults are used throughout: CODE_LEN=3, code 101, MAX_TRIES=3, LOCKOUT_CYCLES=16.
- Reset, then strobe 1,0,1 → after the third edge unlock_led=1, lock_led=0, q=101, fail_cnt=0. Pulse relock → lock_led=1, q=000.
- Strobe 0,1,1 → unlock_led stays 0, q=000, fail_cnt=1. Then strobe 1,0,1 → unlock_led=1, fail_cnt=0.
- Three wrong codes (000, 111, 011) → alarm_led=1 for exactly 16 cycles. Strobing 1,0,1 during lockout has no effect. Afterwards lock_led=1, fail_cnt=0, and 1,0,1 unlocks.
- Strobe 1, idle 2 cycles, 0, idle 1 cycle, 1 → unlocks (gaps tolerated).
- Strobe 1,0, then assert clr_n=0 mid-cycle → q=000 and lock_led=1 immediately without a clock edge. After release, 1,0,1 unlocks.
- With COMBO_LOCK_PROG_EN: unlock, strobe 1,1,0, pulse prog → LOCKED. Then 1,0,1 fails (fail_cnt=1) and 1,1,0 unlocks. Without the macro, the same stimulus leaves code 101 in effect.

Source files
------------

// File: rtl/combo_lock_param.sv
// combo_lock_param: bit-serial combination lock with a failed-attempt counter
// and a timed lockout after too many consecutive wrong codes.
// Optional feature macro: COMBO_LOCK_PROG_EN. When it is defined, a new code
// can be loaded while UNLOCKED. When it is undefined, the code is fixed at
// CODE_DEFAULT and the prog port is ignored.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// LOCKED   | collecting code bits; a completed wrong code counts a failure
// UNLOCKED | correct code entered; bits shift in for reprogramming
// LOCKOUT  | too many failures; all inputs ignored until the timer expires
module combo_lock_param #(
  parameter int                 CODE_LEN       = 3,
  parameter logic [CODE_LEN-1:0] CODE_DEFAULT  = CODE_LEN'(5),
  parameter int                 MAX_TRIES      = 3,
  parameter int                 LOCKOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             clr_n,
  input  logic                             data_in,
  input  logic                             data_valid,
  input  logic                             relock,
  input  logic                             prog,
  output logic [CODE_LEN-1:0]              q,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_cnt,
  output logic                             lock_led,
  output logic                             unlock_led,
  output logic                             alarm_led
);

  localparam int BW = $clog2(CODE_LEN + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [BW-1:0] BIT_LAST   = BW'(CODE_LEN - 1);
  localparam logic [BW-1:0] BIT_FULL   = BW'(CODE_LEN);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_TRIES);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CODE_LEN-1:0] shift_q, shift_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FW-1:0]       fail_q, fail_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [CODE_LEN-1:0] code;
  logic [CODE_LEN-1:0] shifted;
  logic [FW-1:0]       fail_inc;

`ifdef COMBO_LOCK_PROG_EN
  logic [CODE_LEN-1:0] code_q, code_d;

  // Stored code register, reloaded by a programming request.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) code_q <= CODE_DEFAULT;
    else        code_q <= code_d;
  end

  assign code = code_q;
`else
  logic unused_prog;

  assign unused_prog = prog;
  assign code        = CODE_DEFAULT;
`endif

  // State, shift register, bit/fail counters and lockout down-counter.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= LOCKED;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      fail_q    <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      fail_q    <= fail_d;
      timer_q   <= timer_d;
    end
  end

  // Next-state logic: code entry, compare, lockout timing and programming.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    fail_d    = fail_q;
    timer_d   = timer_q;
`ifdef COMBO_LOCK_PROG_EN
    code_d    = code_q;
`endif
    shifted   = {shift_q[CODE_LEN-2:0], data_in};
    fail_inc  = fail_q + FW'(1);

    case (state_q)
      LOCKED: begin
        if (data_valid) begin
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            if (shifted == code) begin
              state_d = UNLOCKED;
              shift_d = shifted;
              fail_d  = '0;
            end else begin
              shift_d = '0;
              fail_d  = fail_inc;
              if (fail_inc == FAIL_MAX) begin
                state_d = LOCKOUT;
                timer_d = TIMER_LOAD;
              end
            end
          end else begin
            shift_d   = shifted;
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      UNLOCKED: begin
`ifdef COMBO_LOCK_PROG_EN
        if (prog && (bit_cnt_q == BIT_FULL)) begin
          code_d    = shift_q;
          state_d   = LOCKED;
          shift_d   = '0;
          bit_cnt_d = '0;
        end else
`endif
        if (relock) begin
          state_d   = LOCKED;
          shift_d   = '0;
          bit_cnt_d = '0;
        end else if (data_valid) begin
          shift_d = shifted;
          if (bit_cnt_q != BIT_FULL) bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      LOCKOUT: begin
        // Timer was loaded with LOCKOUT_CYCLES; leaving on the count of 1
        // keeps alarm_led high for exactly that many cycles.
        timer_d = timer_q - TW'(1);
        if (timer_q == TW'(1)) begin
          state_d = LOCKED;
          fail_d  = '0;
          shift_d = '0;
        end
      end
      default: state_d = LOCKED;
    endcase
  end

  assign q          = shift_q;
  assign fail_cnt   = fail_q;
  assign lock_led   = (state_q != UNLOCKED);
  assign unlock_led = (state_q == UNLOCKED);
  assign alarm_led  = (state_q == LOCKOUT);

endmodule

// File: tb/tb_combo_lock_param.sv
// Directed bench for combo_lock_param with default parameters (code 101,
// three tries, 16-cycle lockout). Expected values go into a queue as the
// stimulus is driven and are popped when the corresponding output is sampled.
module tb_combo_lock_param;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       data_in = 1'b0;
  logic       data_valid = 1'b0;
  logic       relock = 1'b0;
  logic       prog = 1'b0;
  logic [2:0] q;
  logic [1:0] fail_cnt;
  logic       lock_led;
  logic       unlock_led;
  logic       alarm_led;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  combo_lock_param dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .relock     (relock),
    .prog       (prog),
    .q          (q),
    .fail_cnt   (fail_cnt),
    .lock_led   (lock_led),
    .unlock_led (unlock_led),
    .alarm_led  (alarm_led)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  // One clock: inputs change on the falling edge, outputs sampled 1 after rise.
  task automatic cyc(input logic d, input logic dv, input logic rl, input logic pg);
    @(negedge clk);
    data_in = d; data_valid = dv; relock = rl; prog = pg;
    @(posedge clk);
    #1;
  endtask

  task automatic code3(input logic [2:0] c);
    cyc(c[2], 1'b1, 1'b0, 1'b0);
    cyc(c[1], 1'b1, 1'b0, 1'b0);
    cyc(c[0], 1'b1, 1'b0, 1'b0);
  endtask

  task automatic expect_unlocked(input string tag, input logic [2:0] code);
    push(32'd1); check({tag, "_unlock"}, 32'(unlock_led));
    push(32'd0); check({tag, "_lock"}, 32'(lock_led));
    push(32'(code)); check({tag, "_q"}, 32'(q));
    push(32'd0); check({tag, "_fail"}, 32'(fail_cnt));
  endtask

  task automatic do_relock(input string tag);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    push(32'd1); check({tag, "_lock"}, 32'(lock_led));
    push(32'd0); check({tag, "_q"}, 32'(q));
  endtask

  initial begin
    int alarm_cycles;
    int seen_unlock;

    // Reset state
    #12;
    push(32'd1); check("rst_lock", 32'(lock_led));
    push(32'd0); check("rst_unlock", 32'(unlock_led));
    push(32'd0); check("rst_alarm", 32'(alarm_led));
    push(32'd0); check("rst_q", 32'(q));
    push(32'd0); check("rst_fail", 32'(fail_cnt));
    @(negedge clk);
    clr_n = 1'b1;

    // Correct code, with q tracked bit by bit
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    push(32'b001); check("shift1_q", 32'(q));
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    push(32'b010); check("shift2_q", 32'(q));
    push(32'd1); check("shift2_lock", 32'(lock_led));
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    expect_unlocked("open1", 3'b101);
    do_relock("relock1");

    // One wrong code then the right one
    code3(3'b011);
    push(32'd0); check("wrong1_unlock", 32'(unlock_led));
    push(32'd0); check("wrong1_q", 32'(q));
    push(32'd1); check("wrong1_fail", 32'(fail_cnt));
    code3(3'b101);
    expect_unlocked("open2", 3'b101);

    // Relock wins over a simultaneous data strobe
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    push(32'd1); check("relock_dv_lock", 32'(lock_led));
    push(32'd0); check("relock_dv_q", 32'(q));

    // Three wrong codes -> lockout
    code3(3'b000);
    push(32'd1); check("lo_fail1", 32'(fail_cnt));
    code3(3'b111);
    push(32'd2); check("lo_fail2", 32'(fail_cnt));
    code3(3'b011);
    push(32'd3); check("lo_fail3", 32'(fail_cnt));
    push(32'd1); check("lo_alarm_on", 32'(alarm_led));
    push(32'd1); check("lo_lock_on", 32'(lock_led));
    alarm_cycles = alarm_led ? 1 : 0;
    seen_unlock = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      else if (i == 1) cyc(1'b0, 1'b1, 1'b0, 1'b0);
      else if (i == 2) cyc(1'b1, 1'b1, 1'b0, 1'b0);
      else cyc(1'b0, 1'b0, 1'b0, 1'b0);
      if (unlock_led) seen_unlock = 1;
      if (!alarm_led) break;
      alarm_cycles++;
    end
    push(32'd16); check("lo_alarm_cycles", 32'(alarm_cycles));
    push(32'd0); check("lo_no_unlock", 32'(seen_unlock));
    push(32'd1); check("lo_after_lock", 32'(lock_led));
    push(32'd0); check("lo_after_fail", 32'(fail_cnt));
    push(32'd0); check("lo_after_q", 32'(q));
    code3(3'b101);
    expect_unlocked("lo_open", 3'b101);
    do_relock("relock2");

    // Gaps between strobes are tolerated
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    push(32'b010); check("gap_q", 32'(q));
    push(32'd1); check("gap_lock", 32'(lock_led));
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    expect_unlocked("gap_open", 3'b101);
    do_relock("relock3");

    // Asynchronous reset mid-entry
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    data_valid = 1'b0;
    #2;
    clr_n = 1'b0;
    #1;
    push(32'd0); check("arst_q", 32'(q));
    push(32'd1); check("arst_lock", 32'(lock_led));
    @(negedge clk);
    clr_n = 1'b1;
    code3(3'b101);
    expect_unlocked("arst_open", 3'b101);

    // Programming attempt with new code 110
    code3(3'b110);
    push(32'b110); check("prog_shift_q", 32'(q));
    push(32'd1); check("prog_shift_unlock", 32'(unlock_led));
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef COMBO_LOCK_PROG_EN
    push(32'd1); check("prog_lock", 32'(lock_led));
    push(32'd0); check("prog_q", 32'(q));
    code3(3'b101);
    push(32'd0); check("prog_old_unlock", 32'(unlock_led));
    push(32'd1); check("prog_old_fail", 32'(fail_cnt));
    code3(3'b110);
    expect_unlocked("prog_new_open", 3'b110);
`else
    push(32'd1); check("noprog_unlock", 32'(unlock_led));
    push(32'b110); check("noprog_q", 32'(q));
    do_relock("relock4");
    code3(3'b101);
    expect_unlocked("noprog_open", 3'b101);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
